// File: rtl/fft_peak_finder_if.sv
`default_nettype none
// ============================================================================
// fft_peak_finder_if : magnitude stream bundle (amp, sop, valid, eop)
// Rev 1.0
// ============================================================================
interface fft_peak_finder_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] amp_in;
  logic             amp_sop;
  logic             amp_valid;
  logic             amp_eop;

  modport master (output amp_in, output amp_sop, output amp_valid, output amp_eop);
  modport slave  (input  amp_in, input  amp_sop, input  amp_valid, input  amp_eop);
endinterface
`default_nettype wire

// File: rtl/fft_peak_finder.sv
`default_nettype none
// ============================================================================
// fft_peak_finder : per-frame peak bin / magnitude / sum over positive half
// Rev 1.0
// ============================================================================
module fft_peak_finder #(
  parameter int WIDTH     = 16,
  parameter int NPOINT    = 1024,
  parameter int IDX_W     = 10,
  parameter int SKIP_BINS = 2
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  fft_peak_finder_if.slave            s_if,
  output logic [IDX_W-1:0]            peak_idx,
  output logic [WIDTH-1:0]            peak_amp,
  output logic [WIDTH+IDX_W-1:0]      amp_sum,
  output logic                        frame_done,
  output logic                        frame_err,
  output logic                        busy
);
  localparam int SUM_W = WIDTH + IDX_W;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_REPORT  = 2'd2;

  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(NPOINT - 1);
  localparam logic [IDX_W-1:0] LO_BIN   = IDX_W'(SKIP_BINS);
  localparam logic [IDX_W-1:0] HI_BIN   = IDX_W'(NPOINT / 2 - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] snap_max_q, snap_max_d;
  logic [IDX_W-1:0] snap_idx_q, snap_idx_d;
  logic [SUM_W-1:0] snap_sum_q, snap_sum_d;
  logic [IDX_W-1:0] peak_idx_q, peak_idx_d;
  logic [WIDTH-1:0] peak_amp_q, peak_amp_d;
  logic [SUM_W-1:0] amp_sum_q, amp_sum_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             w_beat, w_start, w_in_range, w_gt;
  logic [IDX_W-1:0] w_k, w_base_idx, w_upd_idx;
  logic [WIDTH-1:0] w_base_max, w_upd_max;
  logic [SUM_W-1:0] w_base_sum, w_upd_sum;

  // A sop beat restarts at bin 0 with cleared working values, so the
  // same bin update path serves both frame start and continuation.
  always_comb begin
    w_beat     = s_if.amp_valid;
    w_start    = s_if.amp_valid && s_if.amp_sop;
    w_k        = w_start ? '0 : bin_q;
    w_base_max = w_start ? '0 : max_q;
    w_base_idx = w_start ? '0 : idx_q;
    w_base_sum = w_start ? '0 : sum_q;
    w_in_range = (w_k >= LO_BIN) && (w_k <= HI_BIN);
    w_gt       = w_in_range && (s_if.amp_in > w_base_max);
    w_upd_max  = w_gt ? s_if.amp_in : w_base_max;
    w_upd_idx  = w_gt ? w_k : w_base_idx;
    w_upd_sum  = w_in_range ? (w_base_sum + SUM_W'(s_if.amp_in)) : w_base_sum;
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    max_d      = max_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    snap_max_d = snap_max_q;
    snap_idx_d = snap_idx_q;
    snap_sum_d = snap_sum_q;
    peak_idx_d = peak_idx_q;
    peak_amp_d = peak_amp_q;
    amp_sum_d  = amp_sum_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          max_d   = w_upd_max;
          idx_d   = w_upd_idx;
          sum_d   = w_upd_sum;
          bin_d   = IDX_W'(1);
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (w_start) begin
          err_d = 1'b1;
          max_d = w_upd_max;
          idx_d = w_upd_idx;
          sum_d = w_upd_sum;
          bin_d = IDX_W'(1);
        end else if (w_beat) begin
          if (s_if.amp_eop && (bin_q == LAST_BIN)) begin
            snap_max_d = w_upd_max;
            snap_idx_d = w_upd_idx;
            snap_sum_d = w_upd_sum;
            state_d    = S_REPORT;
          end else if (s_if.amp_eop || (bin_q == LAST_BIN)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            max_d = w_upd_max;
            idx_d = w_upd_idx;
            sum_d = w_upd_sum;
            bin_d = bin_q + IDX_W'(1);
          end
        end
      end
      S_REPORT: begin
        done_d     = 1'b1;
        peak_idx_d = snap_idx_q;
        peak_amp_d = snap_max_q;
        amp_sum_d  = snap_sum_q;
        state_d    = S_IDLE;
        if (w_start) begin
          max_d   = w_upd_max;
          idx_d   = w_upd_idx;
          sum_d   = w_upd_sum;
          bin_d   = IDX_W'(1);
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      max_q      <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      snap_max_q <= '0;
      snap_idx_q <= '0;
      snap_sum_q <= '0;
      peak_idx_q <= '0;
      peak_amp_q <= '0;
      amp_sum_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      max_q      <= max_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      snap_max_q <= snap_max_d;
      snap_idx_q <= snap_idx_d;
      snap_sum_q <= snap_sum_d;
      peak_idx_q <= peak_idx_d;
      peak_amp_q <= peak_amp_d;
      amp_sum_q  <= amp_sum_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign peak_idx   = peak_idx_q;
  assign peak_amp   = peak_amp_q;
  assign amp_sum    = amp_sum_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: doc/fft_peak_finder.md
Name: fft_peak_finder

Overview:
- Sink for the magnitude stream produced by the FFT + modulus path (amp, sop, valid, eop).
- Collects one N-point frame and locates the strongest bin in the positive-frequency half, excluding the lowest SKIP_BINS bins.
- Reports peak bin index, peak magnitude and in-range magnitude sum with a one-cycle done pulse.
- Flags malformed frames; feeds the display/measurement logic.

Parameters:
- WIDTH, 16, magnitude width.
- NPOINT, 1024, FFT length (power of two).
- IDX_W, 10, bin index width, log2(NPOINT).
- SKIP_BINS, 2, lowest bins excluded from the search (DC leakage).

Ports:
- clk  in  1  system clock, same clock as the FFT/modulus stream.
- rst_n  in  1  asynchronous active-low reset.
- amp_in  in  WIDTH  unsigned magnitude beat.
- amp_sop  in  1  first bin of frame, qualified by amp_valid.
- amp_valid  in  1  beat valid.
- amp_eop  in  1  last bin of frame, qualified by amp_valid.
- peak_idx  out  IDX_W  bin index of the maximum.
- peak_amp  out  WIDTH  magnitude of the maximum.
- amp_sum  out  WIDTH+IDX_W  sum of amp_in over the search range.
- frame_done  out  1  one-cycle pulse; result outputs just updated.
- frame_err  out  1  one-cycle pulse; frame discarded.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, all working and snapshot registers 0. Reset is asynchronous and honoured mid-frame; the partial frame is lost and no pulse is generated.
- Beat definition: a beat is any cycle with amp_valid=1. sop and eop are ignored when amp_valid=0.
- States: IDLE, COLLECT, REPORT.
- IDLE:
  - A beat with sop starts a frame: bin 0 is this beat, next bin counter = 1, working max/idx/sum cleared.
  - Go to COLLECT.
  - Beats without sop are ignored.
- COLLECT, each beat at bin k:
  - If SKIP_BINS <= k <= NPOINT/2-1: add amp_in to the working sum.
  - In that same range, if amp_in > working max (strict), load max=amp_in and idx=k. Ties keep the lowest index.
  - Bin counter increments per beat and wraps at NPOINT.
- End of frame:
  - A beat with eop and k == NPOINT-1 is the normal end: copy working max/idx/sum to snapshot registers, go to REPORT.
  - eop with k != NPOINT-1: frame_err pulse next cycle, results unchanged, go to IDLE.
  - k == NPOINT-1 without eop: same error handling as eop mismatch.
- sop while in COLLECT:
  - Current frame is aborted with a frame_err pulse.
  - The sop beat starts a new frame as bin 0; stay in COLLECT.
- sop together with eop on the same beat: treated as sop (restart plus error) unless NPOINT==1 (unsupported).
- REPORT (one cycle):
  - At its closing edge, peak_idx/peak_amp/amp_sum load from the snapshot and frame_done=1 for one cycle.
  - Latency: eop beat sampled at edge E0 -> outputs and frame_done valid from edge E1 (one cycle later).
  - Next state is IDLE.
  - A sop beat during REPORT is accepted as the start of a new frame (bin 0, next state COLLECT). The report still completes from the snapshot.
- Outputs hold between frames. frame_err never alters the result outputs.
- frame_done and frame_err are never high together.
- Width rules: sum accumulator is WIDTH+IDX_W bits and cannot overflow (at most NPOINT/2 terms). All comparisons are unsigned.

Test Plan:
1. Reset; 1024-beat frame with amp=bin index mod 256 except amp[100]=5000 -> peak_idx=100, peak_amp=5000, frame_done high exactly 1 cycle, one cycle after the eop beat.
2. Frame with amp[0]=amp[1]=60000, amp[600]=50000, amp[37]=amp[200]=900, all other bins 1 -> DC and mirror bins ignored, peak_idx=37 (tie keeps lowest), peak_amp=900, amp_sum=1800+508=2308.
3. eop asserted at bin 500 -> frame_err 1-cycle pulse, frame_done stays 0, previous results unchanged, busy falls.
4. Valid frame with amp_valid de-asserted on random cycles (50% duty) -> identical results to the gap-free run of scenario 1.
5. New sop at bin 300 mid-frame, followed by a full valid frame -> one frame_err, then frame_done with results of the second frame only.
6. rst_n pulsed low at bin 700 asynchronously (mid-cycle) -> outputs 0 immediately, busy=0, no pulses; next full frame reports correctly.
